// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and one uart_tx.
// req_lock is present only when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_valid;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_ready;
  logic                         busy;
  logic                         timeout_err;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]           req_lock;

  modport master (
    input  req_valid, req_data, req_lock, tx_ready,
    output req_ack, grant, tx_valid, tx_data, busy, timeout_err
  );
  modport slave (
    output req_valid, req_data, req_lock, tx_ready,
    input  req_ack, grant, tx_valid, tx_data, busy, timeout_err
  );
`else
  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ack, grant, tx_valid, tx_data, busy, timeout_err
  );
  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ack, grant, tx_valid, tx_data, busy, timeout_err
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to let an owner hold the serializer across frames via req_lock.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d, grant_q, grant_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 busy_q;
  logic                 tout_q, tout_d;

  logic [PW-1:0] win, sel;
  logic          found, lock_hit;

  // Scan downward so the requester closest to rr_q is the last (winning) assignment.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (bus.req_valid[(int'(rr_q) + off) % NUM_REQ]) begin
        win   = PW'((int'(rr_q) + off) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic [PW-1:0] own_q, own_d;
  logic          own_vld_q, own_vld_d;
  assign lock_hit = own_vld_q && bus.req_lock[own_q] && bus.req_valid[own_q];
  assign sel      = lock_hit ? own_q : win;
`else
  assign lock_hit = 1'b0;
  assign sel      = win;
`endif

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    grant_d    = grant_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tout_d     = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    own_d      = own_q;
    own_vld_d  = own_vld_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found && bus.tx_ready) begin
          state_d    = ISSUE;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          tx_data_d  = bus.req_data[int'(sel)*DATA_BITS +: DATA_BITS];
          grant_d    = NUM_REQ'(1) << sel;
          ack_d      = NUM_REQ'(1) << sel;
          if (!lock_hit) rr_d = PW'((int'(win) + 1) % NUM_REQ);
`ifdef UART_TX_ARB_LOCK_EN
          own_d      = sel;
          own_vld_d  = 1'b1;
`endif
        end
      end
      ISSUE: begin
        if (!bus.tx_ready) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = DRAIN;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          // Serializer never accepted: drop the byte, its source was already acked.
          tx_valid_d = 1'b0;
          grant_d    = '0;
          tout_d     = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          own_vld_d  = 1'b0;
`endif
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.tx_ready) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      tout_q     <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      own_q      <= '0;
      own_vld_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= (state_d != IDLE);
      tout_q     <= tout_d;
`ifdef UART_TX_ARB_LOCK_EN
      own_q      <= own_d;
      own_vld_q  <= own_vld_d;
`endif
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.grant       = grant_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tout_q;
endmodule
